// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and the decode stage.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_READ  = 2'd1,
    FETCH_FULL  = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_t;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int IMM_MSB    = 15;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  function automatic logic [31:0] byte_swap(input logic [31:0] word);
    return {word[7:0], word[15:8], word[23:16], word[31:24]};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_field_decode.sv
// Combinational field slicing of a 32-bit instruction; shared with the decode stage.
import instruction_fetch_unit_pkg::*;

module instr_field_decode (
  input  logic [31:0] instruction,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] itype_immediate,
  output logic        msb
);

  assign opcode          = instruction[OPCODE_MSB:OPCODE_LSB];
  assign rs              = instruction[RS_MSB:RS_LSB];
  assign rt              = instruction[RT_MSB:RT_LSB];
  assign rd              = instruction[RD_MSB:RD_LSB];
  assign itype_immediate = instruction[IMM_MSB:0];
  assign msb             = instruction[IMM_MSB];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Avalon-MM instruction fetch with valid/ready hand-off and flush.
// Define FETCH_BYTE_SWAP_EN to byte-reverse read data for a little-endian memory.
//   state | meaning
//   IDLE  | waiting for an aligned fetch_req
//   READ  | bus cycle in flight, data will be kept
//   FULL  | instruction held for decode
//   DRAIN | bus cycle in flight after flush, data discarded
import instruction_fetch_unit_pkg::*;

module instruction_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] itype_immediate,
  output logic        msb,
  output logic [31:0] fetch_addr,
  output logic        misaligned
);

  fetch_state_t state, next_state;
  logic         accept_req;
  logic         reject_req;
  logic         load_instr;
  logic [31:0]  load_data;

`ifdef FETCH_BYTE_SWAP_EN
  assign load_data = byte_swap(avm_readdata);
`else
  assign load_data = avm_readdata;
`endif

  always_comb begin
    next_state = state;
    accept_req = 1'b0;
    reject_req = 1'b0;
    load_instr = 1'b0;
    case (state)
      FETCH_IDLE: begin
        if (fetch_req) begin
          if (pc[1:0] == 2'b00) begin
            accept_req = 1'b1;
            next_state = FETCH_READ;
          end else begin
            reject_req = 1'b1;
          end
        end
      end
      FETCH_READ: begin
        if (!avm_waitrequest) begin
          if (flush) begin
            next_state = FETCH_IDLE;
          end else begin
            load_instr = 1'b1;
            next_state = FETCH_FULL;
          end
        end else if (flush) begin
          next_state = FETCH_DRAIN;
        end
      end
      FETCH_FULL: begin
        if (flush || instr_ready) next_state = FETCH_IDLE;
      end
      FETCH_DRAIN: begin
        if (!avm_waitrequest) next_state = FETCH_IDLE;
      end
      default: next_state = FETCH_IDLE;
    endcase
  end

  // The strobe follows the next state so it is registered yet already high on the first READ cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH_IDLE;
      avm_read    <= 1'b0;
      fetch_addr  <= 32'd0;
      instruction <= 32'd0;
      misaligned  <= 1'b0;
    end else begin
      state    <= next_state;
      avm_read <= (next_state == FETCH_READ) || (next_state == FETCH_DRAIN);
      if (accept_req) fetch_addr <= pc;
      if (load_instr) instruction <= load_data;
      if (reject_req) misaligned <= 1'b1;
    end
  end

  assign avm_address = fetch_addr;
  assign instr_valid = (state == FETCH_FULL);

  instr_field_decode u_field_decode (
    .instruction     (instruction),
    .opcode          (opcode),
    .rs              (rs),
    .rt              (rt),
    .rd              (rd),
    .itype_immediate (itype_immediate),
    .msb             (msb)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, fetch_req, flush, avm_read, avm_waitrequest;
  logic        instr_valid, instr_ready, msb, misaligned;
  logic [31:0] pc, avm_address, avm_readdata, instruction, fetch_addr;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] itype_immediate;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // model: a bus cycle is outstanding, its data is doomed, an instruction is held
  bit          m_bus, m_drop, m_held, m_mis;
  logic [31:0] m_instr, m_addr;

  instruction_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_req       (fetch_req),
    .pc              (pc),
    .flush           (flush),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instruction     (instruction),
    .opcode          (opcode),
    .rs              (rs),
    .rt              (rt),
    .rd              (rd),
    .itype_immediate (itype_immediate),
    .msb             (msb),
    .fetch_addr      (fetch_addr),
    .misaligned      (misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] loaded(input logic [31:0] d);
`ifdef FETCH_BYTE_SWAP_EN
    return ((d & 32'hFF) << 24) | (((d >> 8) & 32'hFF) << 16) |
           (((d >> 16) & 32'hFF) << 8) | (d >> 24);
`else
    return d;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_bus = 0; m_drop = 0; m_held = 0; m_mis = 0;
      m_instr = 32'd0; m_addr = 32'd0;
    end else if (m_bus) begin
      if (!avm_waitrequest) begin
        if (!m_drop && !flush) begin
          m_instr = loaded(avm_readdata);
          m_held  = 1;
        end
        m_bus  = 0;
        m_drop = 0;
      end else if (flush) begin
        m_drop = 1;
      end
    end else if (m_held) begin
      if (flush || instr_ready) m_held = 0;
    end else if (fetch_req) begin
      if (pc % 4 == 0) begin
        m_addr = pc;
        m_bus  = 1;
        m_drop = 0;
      end else begin
        m_mis = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("avm_read", avm_read, m_bus);
      chk("avm_address", avm_address, m_addr);
      chk("instr_valid", instr_valid, m_held);
      chk("instruction", instruction, m_instr);
      chk("fetch_addr", fetch_addr, m_addr);
      chk("misaligned", misaligned, m_mis);
      chk("opcode", opcode, m_instr >> 26);
      chk("rs", rs, (m_instr >> 21) % 32);
      chk("rt", rt, (m_instr >> 16) % 32);
      chk("rd", rd, (m_instr >> 11) % 32);
      chk("itype_immediate", itype_immediate, m_instr % 65536);
      chk("msb", msb, (m_instr >> 15) % 2);
    end
  end

  task automatic drive(input logic r, input logic fr, input logic [31:0] p, input logic fl,
                       input logic rdy, input logic w, input logic [31:0] d);
    reset = r; fetch_req = fr; pc = p; flush = fl;
    instr_ready = rdy; avm_waitrequest = w; avm_readdata = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rp;
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk("reset avm_read", avm_read, 0);
    chk("reset avm_address", avm_address, 0);
    chk("reset instruction", instruction, 0);
    chk("reset instr_valid", instr_valid, 0);
    chk("reset misaligned", misaligned, 0);

    // zero-wait fetch
    drive(0, 1, 32'hBFC00000, 0, 0, 0, 0);
    chk("zw avm_read", avm_read, 1);
    chk("zw address", avm_address, 32'hBFC00000);
    drive(0, 0, 0, 0, 0, 0, 32'h8C220004);
    chk("zw avm_read low", avm_read, 0);
    chk("zw instr_valid", instr_valid, 1);
    chk("zw opcode", opcode, 6'h23);
    chk("zw rs", rs, 1);
    chk("zw rt", rt, 2);
    chk("zw imm", itype_immediate, 16'h0004);
    chk("zw msb", msb, 0);
    chk("zw model instr", m_instr, loaded(32'h8C220004));
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("zw released", instr_valid, 0);

    // three wait states
    drive(0, 1, 32'h00000100, 0, 0, 0, 0);
    chk("ws avm_read", avm_read, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 32'hAC43FFFC);
      chk("ws address stable", avm_address, 32'h00000100);
      chk("ws strobe stable", avm_read, 1);
      chk("ws not valid", instr_valid, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 32'hAC43FFFC);
    chk("ws instr_valid", instr_valid, 1);
    chk("ws msb", msb, 1);
    chk("ws imm", itype_immediate, 16'hFFFC);

    // decode backpressure, with an ignored fetch_req
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 32'h00000200, 0, 0, 0, 0);
      chk("bp valid held", instr_valid, 1);
      chk("bp instruction held", instruction, 32'hAC43FFFC);
      chk("bp no bus cycle", avm_read, 0);
      chk("bp fetch_addr held", fetch_addr, 32'h00000100);
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("bp idle after ready", instr_valid, 0);
    chk("bp still no read", avm_read, 0);

    // flush while stalled
    drive(0, 1, 32'h00000300, 0, 0, 1, 0);
    chk("fl avm_read", avm_read, 1);
    drive(0, 0, 0, 1, 0, 1, 0);
    chk("fl drain strobe", avm_read, 1);
    drive(0, 0, 0, 0, 1, 1, 0);
    chk("fl drain no valid", instr_valid, 0);
    drive(0, 0, 0, 0, 1, 0, 32'h12345678);
    chk("fl done strobe", avm_read, 0);
    chk("fl no valid", instr_valid, 0);
    chk("fl instr unchanged", instruction, 32'hAC43FFFC);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("fl still no valid", instr_valid, 0);

    // misaligned request, then a good fetch
    drive(0, 1, 32'h00000006, 0, 0, 0, 0);
    chk("ma misaligned", misaligned, 1);
    chk("ma no read", avm_read, 0);
    drive(0, 1, 32'h00000400, 0, 0, 0, 0);
    chk("ma good read", avm_read, 1);
    drive(0, 0, 0, 0, 0, 0, 32'h0400228C);
`ifdef FETCH_BYTE_SWAP_EN
    chk("bs instruction", instruction, 32'h8C220004);
`else
    chk("bs instruction", instruction, 32'h0400228C);
`endif
    chk("ma sticky", misaligned, 1);
    drive(0, 0, 0, 0, 1, 0, 0);

    // reset mid-READ
    drive(0, 1, 32'h00000500, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("rs mid read", avm_read, 1);
    drive(1, 0, 0, 0, 0, 1, 0);
    chk("rs avm_read", avm_read, 0);
    chk("rs avm_address", avm_address, 0);
    chk("rs instruction", instruction, 0);
    chk("rs fetch_addr", fetch_addr, 0);
    chk("rs misaligned", misaligned, 0);
    chk("rs instr_valid", instr_valid, 0);
    chk("rs opcode", opcode, 0);
    chk("rs msb", msb, 0);

    for (int i = 0; i < 4000; i++) begin
      rp = $urandom;
      if ($urandom_range(0, 15) != 0) rp[1:0] = 2'b00;
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, rp,
            $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) < 2, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
